// File: rtl/ring_buffer_tx_pkg.sv
// Shared types and sizing helpers for the transactional TX ring buffer.
package RingBufferPkg;

  typedef enum logic {RBS_IDLE, RBS_TRANS} TRingState;

  localparam int unsigned RB_DATA_W = 16;
  localparam int unsigned RB_ADDR_W = 8;

  // Pointer at the default geometry: one extra wrap bit over the RAM address.
  typedef logic [RB_ADDR_W:0] TPtr;

  function automatic int unsigned depthOf(input int unsigned addrW);
    return 32'd1 << addrW;
  endfunction

endpackage

// File: rtl/ring_buffer_tx_mem.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module ring_buffer_mem
  import RingBufferPkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned ADDR_W = RB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  localparam int unsigned DEPTH = depthOf(ADDR_W);

  logic [DATA_W-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) ram[wrAddr] <= wrData;
  end

  // Output register carries the reset so pop_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst)      rdData <= '0;
    else if (rdEn) rdData <= ram[rdAddr];
  end

endmodule

// File: rtl/ring_buffer_tx.sv
// Transactional ring buffer: uncommitted pushes stay hidden and uncommitted
// pops stay unfreed until commit; rollback restores both working pointers.
module ring_buffer_tx
  import RingBufferPkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned ADDR_W = RB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_request,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_done,
  input  logic              pop_request,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_done,
  input  logic              open,
  input  logic              commit,
  input  logic              rollback,
  output logic [ADDR_W:0]   mem_used,
  output logic [ADDR_W:0]   mem_free,
  output logic              overflow
);

  localparam int unsigned     PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = PTR_W'(depthOf(ADDR_W));

  TRingState       state, stateNx;
  logic [ADDR_W:0] wrPtr, wrCommit, rdPtr, rdCommit;
  logic [ADDR_W:0] wrPtrNx, wrCommitNx, rdPtrNx, rdCommitNx;
  logic            full, readable, pushAcc, popAcc, refuse;

  assign full     = (wrPtr - rdCommit) == FULL_CNT;
  assign readable = rdPtr != wrCommit;
  // A pending done pulse blocks a new accept, so held requests go at most every other cycle.
  assign pushAcc  = push_request && !full && !push_done;
  assign refuse   = push_request && full && !push_done;
  assign popAcc   = pop_request && readable && !pop_done;

  always_comb begin
    stateNx    = state;
    wrPtrNx    = wrPtr + PTR_W'(pushAcc);
    rdPtrNx    = rdPtr + PTR_W'(popAcc);
    wrCommitNx = wrCommit;
    rdCommitNx = rdCommit;
    case (state)
      RBS_IDLE: begin
        wrCommitNx = wrPtrNx;
        rdCommitNx = rdPtrNx;
        if (open) stateNx = RBS_TRANS;
      end
      RBS_TRANS: begin
        if (rollback) begin
          wrPtrNx = wrCommit;
          rdPtrNx = rdCommit;
          stateNx = RBS_IDLE;
        end else if (commit) begin
          wrCommitNx = wrPtrNx;
          rdCommitNx = rdPtrNx;
          stateNx    = RBS_IDLE;
        end
      end
      default: stateNx = RBS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RBS_IDLE;
      wrPtr     <= '0;
      wrCommit  <= '0;
      rdPtr     <= '0;
      rdCommit  <= '0;
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      overflow  <= 1'b0;
      mem_used  <= '0;
      mem_free  <= FULL_CNT;
    end else begin
      state     <= stateNx;
      wrPtr     <= wrPtrNx;
      wrCommit  <= wrCommitNx;
      rdPtr     <= rdPtrNx;
      rdCommit  <= rdCommitNx;
      push_done <= pushAcc;
      pop_done  <= popAcc;
      overflow  <= refuse;
      mem_used  <= wrCommitNx - rdPtrNx;
      mem_free  <= FULL_CNT - (wrPtrNx - rdCommitNx);
    end
  end

  ring_buffer_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uMem (
    .clk   (clk),
    .rst   (rst),
    .wrEn  (pushAcc),
    .wrAddr(wrPtr[ADDR_W-1:0]),
    .wrData(push_data),
    .rdEn  (popAcc),
    .rdAddr(rdPtr[ADDR_W-1:0]),
    .rdData(pop_data)
  );

endmodule

// File: tb/tb_ring_buffer_tx.sv
// Scoreboard bench for ring_buffer_tx: a 256-deep instance for transactions
// and a 4-deep instance for overflow and wrap-around.
module tb_ring_buffer_tx;

  logic clk;
  logic rst;

  logic        aPushReq, aPushDone, aPopReq, aPopDone, aOpen, aCommit, aRollback, aOverflow;
  logic [15:0] aPushData, aPopData;
  logic [8:0]  aMemUsed, aMemFree;

  logic        bPushReq, bPushDone, bPopReq, bPopDone, bOpen, bCommit, bRollback, bOverflow;
  logic [15:0] bPushData, bPopData;
  logic [2:0]  bMemUsed, bMemFree;

  int tests = 0;
  int fails = 0;
  logic [15:0] qA[$];
  logic [15:0] qB[$];

  ring_buffer_tx #(.DATA_W(16), .ADDR_W(8)) dutA (
    .clk(clk), .rst(rst),
    .push_request(aPushReq), .push_data(aPushData), .push_done(aPushDone),
    .pop_request(aPopReq), .pop_data(aPopData), .pop_done(aPopDone),
    .open(aOpen), .commit(aCommit), .rollback(aRollback),
    .mem_used(aMemUsed), .mem_free(aMemFree), .overflow(aOverflow)
  );

  ring_buffer_tx #(.DATA_W(16), .ADDR_W(2)) dutB (
    .clk(clk), .rst(rst),
    .push_request(bPushReq), .push_data(bPushData), .push_done(bPushDone),
    .pop_request(bPopReq), .pop_data(bPopData), .pop_done(bPopDone),
    .open(bOpen), .commit(bCommit), .rollback(bRollback),
    .mem_used(bMemUsed), .mem_free(bMemFree), .overflow(bOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushA(input logic [15:0] d);
    logic seen;
    seen = 1'b0;
    aPushReq = 1'b1;
    aPushData = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (aPushDone) seen = 1'b1;
    end
    aPushReq = 1'b0;
    check("a_push_done", 32'(seen), 32'd1);
  endtask

  task automatic popA(input logic [15:0] exp);
    logic seen;
    seen = 1'b0;
    qA.push_back(exp);
    aPopReq = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (aPopDone) seen = 1'b1;
    end
    aPopReq = 1'b0;
    check("a_pop_done", 32'(seen), 32'd1);
  endtask

  task automatic pushB(input logic [15:0] d);
    logic seen;
    seen = 1'b0;
    bPushReq = 1'b1;
    bPushData = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bPushDone) seen = 1'b1;
    end
    bPushReq = 1'b0;
    check("b_push_done", 32'(seen), 32'd1);
  endtask

  task automatic popB(input logic [15:0] exp);
    logic seen;
    seen = 1'b0;
    qB.push_back(exp);
    bPopReq = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bPopDone) seen = 1'b1;
    end
    bPopReq = 1'b0;
    check("b_pop_done", 32'(seen), 32'd1);
  endtask

  // kind: 0 open, 1 commit, 2 rollback
  task automatic ctrlA(input int kind);
    aOpen     = (kind == 0);
    aCommit   = (kind == 1);
    aRollback = (kind == 2);
    tick();
    aOpen = 1'b0; aCommit = 1'b0; aRollback = 1'b0;
  endtask

  initial begin
    int cnt;
    logic seen;
    rst = 1'b0;
    aPushReq = 0; aPushData = '0; aPopReq = 0; aOpen = 0; aCommit = 0; aRollback = 0;
    bPushReq = 0; bPushData = '0; bPopReq = 0; bOpen = 0; bCommit = 0; bRollback = 0;

    // Monitor: every pop_done pops the scoreboard and compares the word.
    fork
      forever begin
        @(negedge clk);
        if (aPopDone === 1'b1) begin
          if (qA.size() == 0) check("a_unexpected_pop", 32'd1, 32'd0);
          else check("a_pop_data", 32'(aPopData), 32'(qA.pop_front()));
        end
        if (bPopDone === 1'b1) begin
          if (qB.size() == 0) check("b_unexpected_pop", 32'd1, 32'd0);
          else check("b_pop_data", 32'(bPopData), 32'(qB.pop_front()));
        end
      end
    join_none

    repeat (2) tick();
    rst = 1'b1;
    check("rst_push_done", 32'(aPushDone), 32'd0);
    check("rst_pop_done", 32'(aPopDone), 32'd0);
    check("rst_overflow", 32'(aOverflow), 32'd0);
    check("rst_pop_data", 32'(aPopData), 32'd0);
    check("rst_mem_used", 32'(aMemUsed), 32'd0);
    check("rst_mem_free", 32'(aMemFree), 32'd256);
    check("rst_b_mem_free", 32'(bMemFree), 32'd4);

    // Plain IDLE traffic
    pushA(16'h1111);
    pushA(16'h2222);
    check("idle_used2", 32'(aMemUsed), 32'd2);
    check("idle_free2", 32'(aMemFree), 32'd254);
    popA(16'h1111);
    popA(16'h2222);
    check("idle_used0", 32'(aMemUsed), 32'd0);
    check("idle_free0", 32'(aMemFree), 32'd256);

    // Commit makes pushed words visible
    ctrlA(0);
    pushA(16'h3001);
    pushA(16'h3002);
    pushA(16'h3003);
    check("trans_used_hidden", 32'(aMemUsed), 32'd0);
    check("trans_free253", 32'(aMemFree), 32'd253);
    ctrlA(1);
    check("commit_used3", 32'(aMemUsed), 32'd3);
    check("commit_free253", 32'(aMemFree), 32'd253);
    popA(16'h3001);
    popA(16'h3002);
    popA(16'h3003);
    check("drain_free", 32'(aMemFree), 32'd256);

    // Rollback discards pushes; a later pop must keep waiting
    ctrlA(0);
    pushA(16'hAAAA);
    pushA(16'hBBBB);
    ctrlA(2);
    check("rb_used0", 32'(aMemUsed), 32'd0);
    check("rb_free256", 32'(aMemFree), 32'd256);
    cnt = 0;
    aPopReq = 1'b1;
    repeat (8) begin
      tick();
      if (aPopDone) cnt++;
    end
    aPopReq = 1'b0;
    check("rb_pop_waits", 32'(cnt), 32'd0);

    // Rollback restores popped words
    pushA(16'hC000);
    pushA(16'hC001);
    pushA(16'hC002);
    pushA(16'hC003);
    check("pre_used4", 32'(aMemUsed), 32'd4);
    ctrlA(0);
    popA(16'hC000);
    popA(16'hC001);
    check("trans_pop_used2", 32'(aMemUsed), 32'd2);
    check("trans_pop_free_held", 32'(aMemFree), 32'd252);
    ctrlA(2);
    check("rbpop_used4", 32'(aMemUsed), 32'd4);
    popA(16'hC000);
    popA(16'hC001);
    popA(16'hC002);
    popA(16'hC003);
    check("rbpop_drained", 32'(aMemUsed), 32'd0);

    // Reset mid-transaction cancels a push accepted in the reset cycle
    ctrlA(0);
    pushA(16'hDDDD);
    tick();
    aPushReq = 1'b1;
    aPushData = 16'hEEEE;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    aPushReq = 1'b0;
    check("mrst_push_done", 32'(aPushDone), 32'd0);
    check("mrst_pop_done", 32'(aPopDone), 32'd0);
    check("mrst_used", 32'(aMemUsed), 32'd0);
    check("mrst_free", 32'(aMemFree), 32'd256);
    tick();
    check("mrst_push_done_late", 32'(aPushDone), 32'd0);
    pushA(16'hF0F0);
    check("mrst_idle_visible", 32'(aMemUsed), 32'd1);
    popA(16'hF0F0);

    // Small instance: fill, overflow, free one slot, wrap
    pushB(16'h0010);
    pushB(16'h0011);
    pushB(16'h0012);
    pushB(16'h0013);
    tick();
    check("b_full_free0", 32'(bMemFree), 32'd0);
    check("b_full_used4", 32'(bMemUsed), 32'd4);
    bPushReq = 1'b1;
    bPushData = 16'h0014;
    tick();
    check("b_overflow", 32'(bOverflow), 32'd1);
    check("b_no_push_done", 32'(bPushDone), 32'd0);
    qB.push_back(16'h0010);
    bPopReq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bPopDone) bPopReq = 1'b0;
      if (bPushDone) seen = 1'b1;
    end
    bPushReq = 1'b0;
    bPopReq = 1'b0;
    check("b_push_after_pop", 32'(seen), 32'd1);
    check("b_used_after", 32'(bMemUsed), 32'd4);
    popB(16'h0011);
    popB(16'h0012);
    popB(16'h0013);
    popB(16'h0014);
    check("b_empty_used", 32'(bMemUsed), 32'd0);
    check("b_empty_free", 32'(bMemFree), 32'd4);

    repeat (3) tick();
    check("a_queue_empty", 32'(qA.size()), 32'd0);
    check("b_queue_empty", 32'(qB.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ring_buffer_tx.md
Name: ring_buffer_tx

Overview:
- Transactional ring buffer between the MIL/SPI link stages.
- Producer side is fed by LinkMil or BusGate; consumer side feeds BusMux or BusPusher.
- The command core drives open/commit/rollback and reads mem_used for status words and SPI transfer sizing.
- Inside a transaction, pushed words stay invisible and popped words stay unfreed until commit; rollback restores both pointers.

Parameters:
- DATA_W, 16, word width (one MIL word).
- ADDR_W, 8, address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge).
- push_request  in  1  producer has a word on push_data.
- push_data  in  DATA_W  word to store.
- push_done  out  1  1-cycle pulse: word accepted.
- pop_request  in  1  consumer wants one word.
- pop_data  out  DATA_W  word read; valid while pop_done=1.
- pop_done  out  1  1-cycle pulse: pop_data valid.
- open  in  1  start transaction.
- commit  in  1  end transaction, keep changes.
- rollback  in  1  end transaction, discard changes.
- mem_used  out  ADDR_W+1  committed words readable (wr_commit - rd_ptr).
- mem_free  out  ADDR_W+1  depth - (wr_ptr - rd_commit).
- overflow  out  1  1-cycle pulse: push refused, buffer full.

Behaviour:
- Pointers are ADDR_W+1 bits (wrap bit): wr_ptr, wr_commit, rd_ptr, rd_commit.
- Full: wr_ptr - rd_commit == 2**ADDR_W.
- Readable: rd_ptr != wr_commit.
- Reset: all pointers 0; state IDLE.
  - push_done, pop_done and overflow are 0.
  - pop_data is 0; mem_used is 0; mem_free is 2**ADDR_W.
- States are IDLE and TRANS.
  - IDLE: an accepted push advances wr_ptr and wr_commit together. An accepted pop advances rd_ptr and rd_commit together.
  - TRANS: a push advances only wr_ptr; a pop advances only rd_ptr.
- Transitions:
  - IDLE to TRANS on open; no snapshot is needed because the committed pointers already equal the working pointers.
  - TRANS to IDLE on commit: wr_commit <= wr_ptr (including a push accepted that cycle); rd_commit <= rd_ptr (including that cycle's pop).
  - TRANS to IDLE on rollback: wr_ptr <= wr_commit and rd_ptr <= rd_commit. A push or pop in the same cycle is discarded, and its done pulse still fires.
- Control priority is rollback > commit > open.
  - open in TRANS is ignored.
  - commit or rollback in IDLE is ignored.
  - open together with commit in IDLE means open.
- Push handshake:
  - Accepted in cycle N if push_request=1 and not full; RAM write occurs at edge N.
  - push_done=1 in cycle N+1.
  - Refused if full: overflow=1 in N+1, no push_done; producer keeps request high.
  - A held request is accepted at most once per 2 cycles: no accept while push_done=1.
- Pop handshake:
  - Accepted in cycle N if pop_request=1, readable, and no pop in flight.
  - RAM read latency 1; pop_data and pop_done=1 in N+1.
  - If not readable, request waits; no error flag.
- Simultaneous push and pop in one cycle are both serviced.
  - Same-address read-during-write is impossible: the read requires committed data and the write targets a free slot.
- mem_used and mem_free are registered from next-state pointers, so they are valid the cycle after the event. mem_used excludes uncommitted pushes.
- Wrap-around: pointer arithmetic is modulo 2**(ADDR_W+1); RAM addressed by low ADDR_W bits.
- Reset mid-transaction: uncommitted data is lost, buffer is empty, and any pending done pulse is cancelled.

Decomposition:
- Package RingBufferPkg: typedef TRingState {RBS_IDLE, RBS_TRANS}; localparam DEPTH function of ADDR_W; pointer typedef.
- Sub-module ring_buffer_mem: simple dual-port RAM, 1 write port, 1 registered read port (1-cycle latency), inferable as block RAM.
- Main module: FSM, pointers, handshakes, level outputs.

Test Plan:
- Push words 16'h1111, 16'h2222 in IDLE -> push_done each; mem_used=2; two pops return 1111 then 2222; mem_used=0.
- open, push 3 words, check mem_used=0 and mem_free=253; commit -> mem_used=3.
- open, push 2 words, rollback -> mem_used=0 and mem_free=256; subsequent pop waits with pop_done never asserted.
- Preload 4 committed words; open, pop 2, rollback -> mem_used=4; re-pop returns the same first word.
- ADDR_W=2: push 4 words then a 5th -> overflow pulse, no push_done; one pop in IDLE -> 5th push accepted; data order preserved across wrap.
- open, push 1 word; assert rst=0 for one cycle mid-transaction -> state IDLE, mem_used=0, mem_free=2**ADDR_W, no done pulses.
